// File: rtl/operand_fetch_stage_if.sv
// Fetch-to-operand-fetch bus: incoming instruction, writeback port and the
// registered operand bundle handed to execute.
interface operand_fetch_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4
);
  logic [DATA_W-1:0]     InPc;
  logic [DATA_W-1:0]     InInstr;
  logic                  InValid;
  logic                  Stall;
  logic                  Flush;
  logic                  WbEnable;
  logic [REG_ADDR_W-1:0] WbRd;
  logic [DATA_W-1:0]     WbData;
  logic [DATA_W-1:0]     OfPc;
  logic [DATA_W-1:0]     OfInstr;
  logic [DATA_W-1:0]     OfOp1;
  logic [DATA_W-1:0]     OfOp2;
  logic [DATA_W-1:0]     OfImmx;
  logic [DATA_W-1:0]     OfBranchTarget;
  logic                  OfValid;

  modport master (
    output InPc, InInstr, InValid, Stall, Flush, WbEnable, WbRd, WbData,
    input  OfPc, OfInstr, OfOp1, OfOp2, OfImmx, OfBranchTarget, OfValid
  );

  modport slave (
    input  InPc, InInstr, InValid, Stall, Flush, WbEnable, WbRd, WbData,
    output OfPc, OfInstr, OfOp1, OfOp2, OfImmx, OfBranchTarget, OfValid
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// SimpleRISC operand fetch: IF/OF latch, 16x32 register file with write-first
// bypass, immediate extension and branch-target generation.
module operand_fetch_stage #(
  parameter int                DATA_W     = 32,
  parameter int                REG_ADDR_W = 4,
  parameter logic [DATA_W-1:0] NOP_INSTR  = 32'h68000000
) (
  input logic                 Clk,
  input logic                 Reset,
  operand_fetch_stage_if.slave bus
);
  localparam int NREGS = 1 << REG_ADDR_W;
  localparam logic [4:0] OP_ST  = 5'd15;
  localparam logic [4:0] OP_RET = 5'd20;
  localparam logic [REG_ADDR_W-1:0] RA_REG = REG_ADDR_W'(NREGS - 1);

  function automatic logic [REG_ADDR_W-1:0] src1_addr(input logic [DATA_W-1:0] instr);
    if (instr[31:27] == OP_RET) return RA_REG;
    return instr[21:18];
  endfunction

  // Stores read their data register (rd) on the second port.
  function automatic logic [REG_ADDR_W-1:0] src2_addr(input logic [DATA_W-1:0] instr);
    if (instr[31:27] == OP_ST) return instr[25:22];
    return instr[17:14];
  endfunction

  function automatic logic signed [DATA_W-1:0] ext_imm(input logic [DATA_W-1:0] instr);
    logic [15:0] lo;
    lo = instr[15:0];
    case (instr[17:16])
      2'b01:   ext_imm = {{(DATA_W-16){1'b0}}, lo};
      2'b10:   ext_imm = {lo, {(DATA_W-16){1'b0}}};
      default: ext_imm = {{(DATA_W-16){lo[15]}}, lo};
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] branch_target(input logic [DATA_W-1:0] pc,
                                                      input logic [DATA_W-1:0] instr);
    logic signed [DATA_W-1:0] off;
    off = {{(DATA_W-27){instr[26]}}, instr[26:0]};
    return pc + off;
  endfunction

  logic [DATA_W-1:0]     rf_q [NREGS];
  logic [DATA_W-1:0]     pc_q, instr_q, op1_q, op2_q, immx_q, bt_q;
  logic                  valid_q;
  logic [DATA_W-1:0]     pc_d, instr_d, op1_d, op2_d, immx_d, bt_d;
  logic                  valid_d;
  logic [DATA_W-1:0]     rd_instr, rd1, rd2;
  logic [REG_ADDR_W-1:0] ra1, ra2;

  // Read stage: a stalled latch re-reads its own fields so a writeback during
  // the stall reaches the held operands.
  always_comb begin
    rd_instr = bus.Stall ? instr_q : bus.InInstr;
    ra1      = src1_addr(rd_instr);
    ra2      = src2_addr(rd_instr);
    rd1      = (bus.WbEnable && bus.WbRd == ra1) ? bus.WbData : rf_q[ra1];
    rd2      = (bus.WbEnable && bus.WbRd == ra2) ? bus.WbData : rf_q[ra2];
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    immx_d  = immx_q;
    bt_d    = bt_q;
    valid_d = valid_q;
    if (bus.Flush) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (bus.Stall) begin
      op1_d = rd1;
      op2_d = rd2;
    end else begin
      pc_d    = bus.InPc;
      instr_d = bus.InValid ? bus.InInstr : NOP_INSTR;
      op1_d   = rd1;
      op2_d   = rd2;
      immx_d  = ext_imm(bus.InInstr);
      bt_d    = branch_target(bus.InPc, bus.InInstr);
      valid_d = bus.InValid;
    end
  end

  // IF/OF latch and register file
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      op1_q   <= '0;
      op2_q   <= '0;
      immx_q  <= '0;
      bt_q    <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      immx_q  <= immx_d;
      bt_q    <= bt_d;
      valid_q <= valid_d;
      if (bus.WbEnable) rf_q[bus.WbRd] <= bus.WbData;
    end
  end

  assign bus.OfPc           = pc_q;
  assign bus.OfInstr        = instr_q;
  assign bus.OfOp1          = op1_q;
  assign bus.OfOp2          = op2_q;
  assign bus.OfImmx         = immx_q;
  assign bus.OfBranchTarget = bt_q;
  assign bus.OfValid        = valid_q;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: constant vector table, directed corner
// sequences and a randomized run against an arithmetic reference model.
module tb_operand_fetch_stage;
  localparam logic [31:0] NOP = 32'h68000000;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  operand_fetch_stage_if bus ();
  operand_fetch_stage dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [31:0] rf_m [16];
  logic [31:0] m_pc, m_instr, m_op1, m_op2, m_immx, m_bt;
  logic        m_valid;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] immx;
    logic [31:0] bt;
    logic [31:0] op1;
    bit          chk_op1;
    bit          chk_bt;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [31:0] opcode_of(input logic [31:0] ins);
    return ins >> 27;
  endfunction

  function automatic int src1(input logic [31:0] ins);
    if (opcode_of(ins) == 32'd20) return 15;
    return int'((ins >> 18) & 32'hF);
  endfunction

  function automatic int src2(input logic [31:0] ins);
    if (opcode_of(ins) == 32'd15) return int'((ins >> 22) & 32'hF);
    return int'((ins >> 14) & 32'hF);
  endfunction

  function automatic logic [31:0] rdreg(input int a);
    if (bus.WbEnable && int'(bus.WbRd) == a) return bus.WbData;
    return rf_m[a];
  endfunction

  function automatic logic [31:0] immx_of(input logic [31:0] ins);
    logic [31:0] imm, lo, m;
    imm = ins & 32'h3FFFF;
    m   = imm >> 16;
    lo  = imm & 32'hFFFF;
    if (m == 1) return lo;
    if (m == 2) return lo * 32'd65536;
    if (lo >= 32768) return lo + 32'hFFFF0000;
    return lo;
  endfunction

  function automatic logic [31:0] bt_of(input logic [31:0] pc, input logic [31:0] ins);
    logic [31:0] off;
    off = ins & 32'h07FFFFFF;
    if (off >= 32'h04000000) off = off + 32'hF8000000;
    return pc + off;
  endfunction

  task automatic model_edge();
    if (!Reset) begin
      for (int i = 0; i < 16; i++) rf_m[i] = '0;
      m_pc = '0; m_instr = NOP; m_op1 = '0; m_op2 = '0;
      m_immx = '0; m_bt = '0; m_valid = 1'b0;
      return;
    end
    if (bus.Flush) begin
      m_valid = 1'b0;
      m_instr = NOP;
    end else if (bus.Stall) begin
      m_op1 = rdreg(src1(m_instr));
      m_op2 = rdreg(src2(m_instr));
    end else begin
      m_op1   = rdreg(src1(bus.InInstr));
      m_op2   = rdreg(src2(bus.InInstr));
      m_pc    = bus.InPc;
      m_instr = bus.InValid ? bus.InInstr : NOP;
      m_immx  = immx_of(bus.InInstr);
      m_bt    = bt_of(bus.InPc, bus.InInstr);
      m_valid = bus.InValid;
    end
    if (bus.WbEnable) rf_m[bus.WbRd] = bus.WbData;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("OfPc", bus.OfPc, m_pc);
    chk("OfInstr", bus.OfInstr, m_instr);
    chk("OfOp1", bus.OfOp1, m_op1);
    chk("OfOp2", bus.OfOp2, m_op2);
    chk("OfImmx", bus.OfImmx, m_immx);
    chk("OfBranchTarget", bus.OfBranchTarget, m_bt);
    chk("OfValid", {31'b0, bus.OfValid}, {31'b0, m_valid});
  endtask

  task automatic drv(input logic [31:0] pc, input logic [31:0] ins, input logic vld,
                     input logic stl, input logic fl, input logic we,
                     input logic [3:0] wrd, input logic [31:0] wd);
    bus.InPc = pc; bus.InInstr = ins; bus.InValid = vld;
    bus.Stall = stl; bus.Flush = fl;
    bus.WbEnable = we; bus.WbRd = wrd; bus.WbData = wd;
  endtask

  task automatic step();
    model_edge();
    @(posedge Clk);
    #1;
    check_all();
  endtask

  initial begin
    tbl[0] = '{32'd3, 32'h0C480003, 32'h00000003, 32'hFC480006, 32'd6, 1'b1, 1'b1};
    tbl[1] = '{32'd0, 32'h0408FFFF, 32'hFFFFFFFF, 32'd0, 32'd6, 1'b1, 1'b0};
    tbl[2] = '{32'd0, 32'h0409FFFF, 32'h0000FFFF, 32'd0, 32'd6, 1'b1, 1'b0};
    tbl[3] = '{32'd0, 32'h040A8001, 32'h80010000, 32'd0, 32'd6, 1'b1, 1'b0};
    tbl[4] = '{32'd0, 32'h040B8000, 32'hFFFF8000, 32'd0, 32'd6, 1'b1, 1'b0};
    tbl[5] = '{32'd10, 32'h97FFFFFC, 32'hFFFFFFFC, 32'd6, 32'd0, 1'b0, 1'b1};
    tbl[6] = '{32'hFFFFFFFF, 32'h90000002, 32'h00000002, 32'd1, 32'd0, 1'b0, 1'b1};

    Reset = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("rst_valid", {31'b0, bus.OfValid}, 32'd0);
    chk("rst_instr", bus.OfInstr, NOP);
    chk("rst_op1", bus.OfOp1, 32'd0);
    chk("rst_op2", bus.OfOp2, 32'd0);
    Reset = 1'b1;

    // preload R2 = 6, then run the constant vector table
    drv(0, 0, 0, 0, 0, 1, 4'd2, 32'd6);
    step();
    foreach (tbl[i]) begin
      drv(tbl[i].pc, tbl[i].instr, 1, 0, 0, 0, 0, 0);
      step();
      chk("tbl_pc", bus.OfPc, tbl[i].pc);
      chk("tbl_instr", bus.OfInstr, tbl[i].instr);
      chk("tbl_valid", {31'b0, bus.OfValid}, 32'd1);
      chk("tbl_immx", bus.OfImmx, tbl[i].immx);
      if (tbl[i].chk_op1) chk("tbl_op1", bus.OfOp1, tbl[i].op1);
      if (tbl[i].chk_bt) chk("tbl_bt", bus.OfBranchTarget, tbl[i].bt);
    end

    // same-edge writeback bypass, then a writeback to an unrelated register
    drv(3, 32'h0C480003, 1, 0, 0, 1, 4'd2, 32'h55);
    step();
    chk("byp_hit", bus.OfOp1, 32'h55);
    drv(3, 32'h0C480003, 1, 0, 0, 1, 4'd3, 32'h99);
    step();
    chk("byp_miss", bus.OfOp1, 32'h55);

    // st R5 held for three stalls, R5 rewritten in the second one
    drv(0, 0, 0, 0, 0, 1, 4'd5, 32'h11);
    step();
    drv(20, 32'h79440004, 1, 0, 0, 0, 0, 0);
    step();
    chk("st_op2", bus.OfOp2, 32'h11);
    for (int s = 1; s <= 3; s++) begin
      drv(99, 32'h12345678, 1, 1, 0, (s == 2), 4'd5, 32'hAB);
      step();
      chk("stall_pc", bus.OfPc, 32'd20);
      chk("stall_instr", bus.OfInstr, 32'h79440004);
      chk("stall_op2", bus.OfOp2, (s == 1) ? 32'h11 : 32'hAB);
    end

    drv(7, 32'h0C480003, 1, 1, 1, 0, 0, 0);
    step();
    chk("flush_valid", {31'b0, bus.OfValid}, 32'd0);
    chk("flush_instr", bus.OfInstr, NOP);

    drv(0, 0, 0, 0, 0, 1, 4'd15, 32'd40);
    step();
    drv(7, 32'hA0000000, 1, 0, 0, 0, 0, 0);
    step();
    chk("ret_op1", bus.OfOp1, 32'd40);

    // reset in the middle of a stall, then confirm the register file cleared
    drv(5, 32'h0C480003, 1, 1, 0, 1, 4'd2, 32'h77);
    Reset = 1'b0;
    step();
    chk("rst_stall_valid", {31'b0, bus.OfValid}, 32'd0);
    chk("rst_stall_instr", bus.OfInstr, NOP);
    chk("rst_stall_pc", bus.OfPc, 32'd0);
    chk("rst_stall_bt", bus.OfBranchTarget, 32'd0);
    Reset = 1'b1;
    drv(3, 32'h0C480003, 1, 0, 0, 0, 0, 0);
    step();
    chk("rf_cleared", bus.OfOp1, 32'd0);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      int          pick;
      ins  = $urandom;
      pick = $urandom_range(0, 5);
      if (pick == 0) ins = (ins & 32'h07FFFFFF) | (32'd15 << 27);
      if (pick == 1) ins = (ins & 32'h07FFFFFF) | (32'd20 << 27);
      Reset = ($urandom_range(0, 59) != 0);
      drv($urandom, ins, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)), $urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- SimpleRISC stage directly downstream of instruction fetch: holds the IF/OF pipeline latch, the 16x32 architectural register file and immediate/branch-target generation.
- Captures {PC, instruction} from fetch and reads two source operands, with write-first bypass from the writeback port.
- Presents registered operands, the extended immediate and the branch target to the execute stage.
- Supports stall (hold) and flush (bubble insert on taken branch).

Parameters:
- DATA_W, 32, operand/PC/instruction width.
- REG_ADDR_W, 4, register index width (16 registers; R15 = return-address register ra).
- NOP_INSTR, 32'h68000000, encoding of nop (opcode 13), loaded on reset and on flush.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising Clk).
- InPc  in  32  PC of the instruction from fetch (word-addressed; fetch increments by 1).
- InInstr  in  32  instruction word from fetch.
- InValid  in  1  fetch output valid.
- Stall  in  1  hold the latch contents this cycle.
- Flush  in  1  taken branch in a later stage; kill the instruction being latched.
- WbEnable  in  1  register-file write enable.
- WbRd  in  4  write register index.
- WbData  in  32  write data.
- OfPc  out  32  latched PC.
- OfInstr  out  32  latched instruction.
- OfOp1  out  32  operand 1.
- OfOp2  out  32  operand 2.
- OfImmx  out  32  extended immediate.
- OfBranchTarget  out  32  OfPc + sign-extended offset.
- OfValid  out  1  latch holds a live instruction.

Behaviour:
- Field decode: opcode = [31:27]; I = [26]; rd = [25:22]; rs1 = [21:18]; rs2 = [17:14]; imm = [17:0]; modifier = [17:16]; offset = [26:0].
- Read address 1: rs1, except ret (opcode 20), which reads R15.
- Read address 2: rs2, except st (opcode 15), which reads rd (the store data).
- Bypass: if WbEnable and WbRd equals a read address in the same cycle, that operand takes WbData (write-first). Applies to all 16 registers; no hardwired zero.
- Immmediate extension (OfImmx):
  - modifier 00: sign-extend imm[15:0].
  - modifier 01: zero-extend imm[15:0].
  - modifier 10: {imm[15:0], 16'h0}.
  - modifier 11: sign-extend imm[15:0].
- OfBranchTarget = InPc + sext(offset[26:0]), modulo 2^32 (wraps silently). Computed at capture from the incoming PC and instruction.
- Register file: written on the rising edge when WbEnable = 1, independent of Stall and Flush. Every register clears to 0 on reset.
- Update priority each rising edge: Reset > Flush > Stall > load.
- Reset (Reset = 0): OfValid = 0, OfInstr = NOP_INSTR, and OfPc, OfOp1, OfOp2, OfImmx, OfBranchTarget = 0. The register file clears in the same edge. Reset mid-stall or mid-flush overrides both.
- Flush = 1: OfValid = 0 and OfInstr = NOP_INSTR. Other outputs are don't-care but must be held (not X). Flush wins over a simultaneous Stall.
- Stall = 1 (no flush):
  - OfPc, OfInstr, OfImmx, OfBranchTarget and OfValid hold.
  - OfOp1/OfOp2 are re-read each stalled cycle from the held OfInstr fields, with bypass, so a writeback during the stall is never lost.
- Load (no stall, no flush): all outputs capture from InPc/InInstr with a latency of 1 cycle. OfValid = InValid. If InValid = 0, OfInstr = NOP_INSTR.
- A register-file write in the same edge as a load is seen by the loaded operands through the bypass.

Test Plan:
- Reset low 2 cycles, then high: OfValid = 0, OfInstr = 32'h68000000, OfOp1/OfOp2 = 0. Load InInstr 32'h0C480003 (sub R1,R2,3) at InPc 3 with R2 = 6 preloaded via WB → next cycle OfOp1 = 6, OfImmx = 3, OfValid = 1, OfPc = 3.
- Bypass: load 32'h0C480003 while WbEnable = 1, WbRd = 2, WbData = 32'h55 in the same edge → OfOp1 = 32'h55. With WbRd = 3 instead → OfOp1 = old R2.
- Immediate modes: imm fields 0x0FFFF, 0x1FFFF and 0x28001 → OfImmx = 32'hFFFFFFFF, 32'h0000FFFF and 32'h80010000 respectively.
- Branch target: InPc = 10 with b offset 27'h7FFFFFC (-4) → OfBranchTarget = 6. InPc = 32'hFFFFFFFF with offset 2 → OfBranchTarget = 1 (wrap).
- Stall 3 cycles holding a st R5 (rd = 5), with WB writing R5 = 32'hAB in stall cycle 2 → OfOp2 = 32'hAB from the following cycle. OfPc and OfInstr remain unchanged throughout.
- Stall and Flush asserted together → OfValid = 0, OfInstr = nop. ret instruction with R15 = 40 → OfOp1 = 40. Reset asserted during a stall → all outputs return to reset values next edge.
